// File: rtl/phase_done_aggregator.sv
// phase_done_aggregator: start N units per phase, gather their done pulses, report phase completion and step count
// Ports: clk, reset (async, active low); phase1_ready/phase3_ready/double_buffer from the control unit;
//   unit_done per-unit done pulses; unit_start/unit_phase/unit_buffer to the units;
//   phase1_done/phase3_done/step back to the control unit; busy, sticky proto_err and timeout_err.
// Define PHASE_TIMEOUT_EN to add a TIMEOUT_CYCLES watchdog on the WAIT state.
module phase_done_aggregator #(
  parameter int N_UNITS = 4,
  parameter int STEP_W = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               phase1_ready,
  input  logic               phase3_ready,
  input  logic               double_buffer,
  input  logic [N_UNITS-1:0] unit_done,
  output logic [N_UNITS-1:0] unit_start,
  output logic               unit_phase,
  output logic               unit_buffer,
  output logic               phase1_done,
  output logic               phase3_done,
  output logic [STEP_W-1:0]  step,
  output logic               busy,
  output logic               proto_err,
  output logic               timeout_err
);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [N_UNITS-1:0] mask;
  logic [N_UNITS-1:0] mask_acc;
  logic ready;
  logic abort;
  logic expired;
  if (N_UNITS < 1 || N_UNITS > 64 || STEP_W < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("phase_done_aggregator: parameter out of range");
  end
  // unit_phase doubles as the phase register: 0 = phase 1, 1 = phase 3
  assign ready = unit_phase ? phase3_ready : phase1_ready;
  assign mask_acc = mask | unit_done;
  assign abort = (state == START || state == WAIT) && !ready;
`ifdef PHASE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  // fires in the TIMEOUT_CYCLES-th WAIT cycle unless that same cycle completes the mask
  assign expired = state == WAIT && !abort && !(&mask_acc) && wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wait_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt <= state == WAIT ? wait_cnt + 1'b1 : '0;
      timeout_err <= timeout_err | expired;
    end
`else
  assign expired = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      mask <= '0;
      unit_start <= '0;
      unit_phase <= 1'b0;
      unit_buffer <= 1'b0;
      phase1_done <= 1'b0;
      phase3_done <= 1'b0;
      step <= '0;
      busy <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      unit_start <= '0;
      // a dropped request wins over a mask completing in the same cycle
      if (abort) begin
        state <= IDLE;
        mask <= '0;
        busy <= 1'b0;
        proto_err <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (phase1_ready || phase3_ready) begin
              state <= START;
              unit_start <= '1;
              unit_phase <= !phase1_ready;
              unit_buffer <= double_buffer;
              busy <= 1'b1;
            end
            if ((phase1_ready && phase3_ready) || |unit_done) proto_err <= 1'b1;
          end
          START: begin
            state <= WAIT;
            mask <= unit_done;
          end
          WAIT: begin
            mask <= mask_acc;
            if (&mask_acc || expired) begin
              state <= DONE;
              phase1_done <= !unit_phase;
              phase3_done <= unit_phase;
              if (unit_phase) step <= step + 1'b1;
            end
          end
          default: begin
            if (!ready) begin
              state <= IDLE;
              mask <= '0;
              busy <= 1'b0;
              phase1_done <= 1'b0;
              phase3_done <= 1'b0;
            end
            if (|unit_done) proto_err <= 1'b1;
          end
        endcase
      end
    end
endmodule

// File: doc/phase_done_aggregator.md
Name: phase_done_aggregator

Overview:
- Compute-side counterpart to the control unit's phase sequencer.
- Consumes `phase1_ready`, `phase3_ready` and `double_buffer`, and broadcasts a start pulse to N processing units.
- Collects each unit's done pulse, then returns `phase1_done` / `phase3_done` and the running timestep `step`.
- Sits between the control unit and the cell/force pipelines.

Parameters:
- N_UNITS, 4, number of processing units whose done pulses are aggregated (1..64)
- STEP_W, 32, width of the step counter
- TIMEOUT_CYCLES, 65535, watchdog limit for the WAIT state (used only with PHASE_TIMEOUT_EN)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- phase1_ready  input  1  level; control unit requests phase 1
- phase3_ready  input  1  level; control unit requests phase 3
- double_buffer  input  1  buffer select from the control unit
- unit_done  input  N_UNITS  per-unit one-cycle done pulse
- unit_start  output  N_UNITS  one-cycle start pulse, all bits asserted together
- unit_phase  output  1  0 = phase 1 running, 1 = phase 3 running
- unit_buffer  output  1  `double_buffer` latched at phase start
- phase1_done  output  1  level; all units finished phase 1
- phase3_done  output  1  level; all units finished phase 3
- step  output  STEP_W  completed phase-3 count
- busy  output  1  high in any state except IDLE
- proto_err  output  1  sticky; protocol violation seen
- timeout_err  output  1  sticky; watchdog expired (0 without the macro)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0; `step`=0; sticky done mask=0.
- All outputs are registered.
- FSM states: IDLE, START, WAIT, DONE. A `phase` register records 1 or 3.
- IDLE:
  - If `phase1_ready`: go to START, phase=1.
  - Else if `phase3_ready`: go to START, phase=3.
  - If both are high: phase 1 wins and `proto_err` is set.
- START (exactly 1 cycle):
  - `unit_start` = all ones.
  - `unit_phase` and `unit_buffer` latched.
  - Sticky mask <= `unit_done` (clear-and-capture).
  - Next state: WAIT.
- WAIT:
  - Sticky mask |= `unit_done` each cycle.
  - When the mask (including the current cycle's `unit_done`) is all ones: go to DONE.
  - The matching `phaseX_done` rises on the same edge.
  - If phase=3, `step` increments on that same edge.
- DONE:
  - Hold `phaseX_done`=1 until the matching ready input deasserts.
  - Then clear done, go to IDLE (1 cycle later), mask=0.
- Latency:
  - Ready high at cycle 0 → `unit_start` at cycle 1.
  - Last `unit_done` at cycle k → done high at cycle k+1.
  - Ready low at cycle m → done low at cycle m+1.
- Ready deasserted during START or WAIT (abort):
  - Return to IDLE next cycle.
  - No done, no step increment, mask cleared.
  - `proto_err` set.
- `unit_done` bit seen twice in one phase: ignored (mask is OR). Not an error.
- `unit_done` nonzero in IDLE or DONE: ignored, `proto_err` set.
- Step wrap-around: `step` wraps from 2^STEP_W-1 to 0 silently.
- `busy` = state != IDLE.
- Sticky errors clear only on reset.

Optional Feature:
- Macro: PHASE_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES before the mask is full: set `timeout_err`, force DONE with the phase's done asserted and step incremented for phase 3.
  - Counter resets on every entry to START.
- Undefined: no counter logic; `timeout_err` tied to 0; WAIT waits indefinitely.

Test Plan:
- Phase 1, normal:
  - Stimulus: reset release, `phase1_ready`=1 at cycle 0, `double_buffer`=1, `unit_done` pulses 0001, 0100, 1010 at cycles 3, 5, 7.
  - Response: `unit_start`=1111 at cycle 1 only; `unit_buffer`=1; `phase1_done`=1 at cycle 8; `step`=0.
- Phase 3, normal:
  - Stimulus: `phase3_ready`=1; all units done at cycle 4; ready drops at cycle 10.
  - Response: `phase3_done`=1 and `step`=1 at cycle 5; `phase3_done`=0 at cycle 11; `busy`=0 at cycle 11.
- Abort and error flags:
  - Stimulus: `phase1_ready` drops in WAIT with mask=0011.
  - Response: no `phase1_done`; IDLE next cycle; `proto_err`=1.
  - Stimulus: `unit_done`=0001 while in IDLE.
  - Response: `proto_err`=1.
- Full loop with wrap:
  - Stimulus: 5 full phase1/phase3 loops with STEP_W=2.
  - Response: `step` sequence 1, 2, 3, 0, 1; done never asserted while `busy` is low.
- Asynchronous reset in WAIT:
  - Stimulus: reset=0 mid-WAIT.
  - Response: outputs 0 immediately (before next edge); `step`=0.
- Timeout (PHASE_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Stimulus: one unit never reports done.
  - Response: `timeout_err`=1 and `phaseX_done`=1 after 16 WAIT cycles.
